// File: rtl/serial_add_pkg.sv
// Shared types and pin map for the bit-serial adder controller.
// The state named DONE and the done pin index cannot share a name, so pin indices carry a PIN_ prefix.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PIN_LOAD_A = 0;
    localparam int PIN_LOAD_B = 1;
    localparam int PIN_START  = 2;
    localparam int PIN_CARRY  = 7;
    localparam int PIN_BUSY   = 6;
    localparam int PIN_DONE   = 5;

    localparam logic [7:0] UIO_OE = 8'b1110_0000;

endpackage

// File: rtl/half_adder_cell.sv
// Single half-adder; two of these plus an OR make the serial full adder.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: byte-wise operand load, WIDTH-cycle serial add,
// start/busy/done handshake on the bidirectional pins.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   result;
    logic               carry;
    logic               start_q;
    logic [CNT_W-1:0]   cnt;

    logic start_evt;
    logic s1, c1, s2, c2;
    logic unused_pins;

    assign start_evt   = uio_in[PIN_START] & ~start_q;
    assign unused_pins = &{1'b0, uio_in[7:3], ui_in};

    half_adder_cell u_ha_ab (
        .a (a_reg[0]),
        .b (b_reg[0]),
        .s (s1),
        .c (c1)
    );

    half_adder_cell u_ha_cin (
        .a (s1),
        .b (carry),
        .s (s2),
        .c (c2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            result  <= '0;
            carry   <= 1'b0;
            start_q <= 1'b0;
            cnt     <= '0;
        end else if (ena) begin
            start_q <= uio_in[PIN_START];
            case (state)
                IDLE, DONE: begin
                    // A start edge wins over any load presented in the same cycle.
                    if (start_evt) begin
                        state  <= RUN;
                        carry  <= 1'b0;
                        result <= '0;
                        cnt    <= '0;
                    end else begin
                        if (uio_in[PIN_LOAD_A]) a_reg <= ui_in[WIDTH-1:0];
                        if (uio_in[PIN_LOAD_B]) b_reg <= ui_in[WIDTH-1:0];
                    end
                end
                RUN: begin
                    result <= {s2, result[WIDTH-1:1]};
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    carry  <= c1 | c2;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out  = 8'(result);
    assign uio_out = {carry, (state == RUN), (state == DONE), 5'b0_0000};
    assign uio_oe  = UIO_OE;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl against a transaction-level sum model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b0;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;
    int ma = 0;
    int mb = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [1:0] mask, input logic [7:0] d);
        uio_in = {6'b0, mask};
        ui_in  = d;
        @(negedge clk);
        uio_in = 8'h00;
        if (mask[0]) ma = d % (1 << W);
        if (mask[1]) mb = d % (1 << W);
    endtask

    // One full addition from start edge to done, checked against plain integer arithmetic.
    task automatic do_run(input string tag, input bit hold, input int disturb_at, input int freeze_at);
        int sum, exp_res, exp_c;
        sum     = ma + mb;
        exp_res = sum % (1 << W);
        exp_c   = (sum >> W) & 1;
        uio_in = 8'h04;
        @(negedge clk);
        if (!hold) uio_in = 8'h00;
        for (int i = 0; i < W; i++) begin
            check({tag, "/busy"}, 32'(uio_out[6]), 1);
            check({tag, "/done_low"}, 32'(uio_out[5]), 0);
            if (i == freeze_at) begin
                ena = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check({tag, "/busy_frozen"}, 32'(uio_out[6]), 1);
                end
                ena = 1'b1;
            end
            if (i == disturb_at) begin
                uio_in = 8'h05;
                ui_in  = 8'h77;
            end else if (!hold) begin
                uio_in = 8'h00;
            end
            @(negedge clk);
        end
        check({tag, "/busy_end"}, 32'(uio_out[6]), 0);
        check({tag, "/done"}, 32'(uio_out[5]), 1);
        check({tag, "/sum"}, 32'(uo_out), 32'(exp_res));
        check({tag, "/carry"}, 32'(uio_out[7]), 32'(exp_c));
        check({tag, "/low_bits"}, 32'(uio_out[4:0]), 0);
        ma = 0;
        mb = 0;
        if (hold) begin
            repeat (20) begin
                @(negedge clk);
                check({tag, "/hold_done"}, 32'(uio_out[5]), 1);
                check({tag, "/hold_busy"}, 32'(uio_out[6]), 0);
                check({tag, "/hold_sum"}, 32'(uo_out), 32'(exp_res));
            end
            uio_in = 8'h00;
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_uo", 32'(uo_out), 0);
        check("rst_uio", 32'(uio_out), 0);
        check("rst_oe", 32'(uio_oe), 32'h E0);
        rst_n = 1'b1;
        ena   = 1'b1;
        @(negedge clk);
        check("oe", 32'(uio_oe), 32'h E0);
        check("idle_busy", 32'(uio_out[6]), 0);

        load(2'b01, 8'h5A);
        load(2'b10, 8'h3C);
        do_run("5a_3c", 0, -1, -1);

        load(2'b01, 8'hFF);
        load(2'b10, 8'h01);
        do_run("ff_01", 0, -1, -1);

        load(2'b11, 8'hFF);
        do_run("ff_ff", 0, -1, -1);

        load(2'b01, 8'h12);
        load(2'b10, 8'h34);
        do_run("hold", 1, -1, -1);

        // Loads and a start edge during RUN must be ignored; A stays consumed.
        load(2'b01, 8'h5A);
        load(2'b10, 8'h3C);
        do_run("disturb", 0, 2, -1);
        load(2'b10, 8'h10);
        do_run("a_consumed", 0, -1, -1);

        // Back-to-back: start accepted on the first done cycle computes 0+0.
        load(2'b11, 8'h81);
        do_run("b2b_first", 0, -1, -1);
        do_run("b2b_second", 0, -1, -1);

        load(2'b01, 8'h5A);
        load(2'b10, 8'h3C);
        do_run("freeze", 0, -1, 4);

        // Reset during the fourth RUN cycle aborts and clears operands.
        load(2'b01, 8'h5A);
        load(2'b10, 8'h3C);
        uio_in = 8'h04;
        @(negedge clk);
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_uo", 32'(uo_out), 0);
        check("abort_uio", 32'(uio_out), 0);
        check("abort_oe", 32'(uio_oe), 32'h E0);
        rst_n = 1'b1;
        ma = 0;
        mb = 0;
        do_run("after_rst_zero", 0, -1, -1);
        load(2'b01, 8'h5A);
        load(2'b10, 8'h3C);
        do_run("after_rst", 0, -1, -1);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] ra, rb;
            int mode;
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 2);
            if (mode == 2) begin
                load(2'b11, ra);
            end else begin
                load(2'b01, ra);
                load(2'b10, rb);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run("rand", 0, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
